// File: rtl/irq_timer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// irq_timer_ctrl_pkg
// Shared CPU-side constants for the interrupt timer peripheral:
//   - register offsets inside the peripheral window
//   - TCON bit indices
//   - controller FSM state encodings (legacy-compatible 2-bit constants)
// ----------------------------------------------------------------------------
package irq_timer_ctrl_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_000C;

    // TCON bit indices
    localparam int TCON_EN     = 0;
    localparam int TCON_IRQ_EN = 1;
    localparam int TCON_STATUS = 2;
    localparam int TCON_W      = 3;

    // Interrupt controller FSM encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PEND    = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

endpackage

// File: rtl/irq_timer_ctrl_if.sv
// ----------------------------------------------------------------------------
// irq_timer_ctrl_if
// CPU data-bus view of the timer peripheral.
//   addr  : CPU data-bus address
//   wdata : store data
//   we    : store strobe, sampled at the clock edge
//   re    : load strobe
//   rdata : load data, combinational from addr/re
// Modports: master (CPU side), slave (peripheral side).
// ----------------------------------------------------------------------------
interface irq_timer_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output we, output re, input rdata);
    modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/irq_timer_ctrl_timer_counter.sv
// ----------------------------------------------------------------------------
// timer_counter
// TH/TL/TCON register file with count, reload-on-overflow and status set.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   wr_th_i/wr_tl_i      : decoded store strobes for TH / TL
//   wr_tcon_i            : decoded store strobe for TCON
//   wdata_i              : store data
//   th_o, tl_o, tcon_o   : current register values
// ----------------------------------------------------------------------------
module timer_counter
    import irq_timer_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_th_i,
    input  logic                wr_tl_i,
    input  logic                wr_tcon_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         th_o,
    output logic [31:0]         tl_o,
    output logic [TCON_W-1:0]   tcon_o
);

    logic [31:0]       th_q, th_d;
    logic [31:0]       tl_q, tl_d;
    logic [TCON_W-1:0] tcon_q, tcon_d;
    logic              overflow;
    logic              set_status;

    assign overflow   = tcon_q[TCON_EN] && (tl_q == 32'hFFFF_FFFF);
    assign set_status = overflow && tcon_q[TCON_IRQ_EN];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;

        if (wr_th_i) th_d = wdata_i;

        // A bus store to TL wins over both reload and counting.
        if (wr_tl_i)                 tl_d = wdata_i;
        else if (overflow)           tl_d = th_q;
        else if (tcon_q[TCON_EN])    tl_d = tl_q + 32'd1;

        // Software may clear status, but an overflow on the same edge re-sets it.
        if (wr_tcon_i) tcon_d = wdata_i[TCON_W-1:0];
        if (set_status) tcon_d[TCON_STATUS] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    assign th_o   = th_q;
    assign tl_o   = tl_q;
    assign tcon_o = tcon_q;

endmodule

// File: rtl/irq_timer_ctrl.sv
// ----------------------------------------------------------------------------
// irq_timer_ctrl
// Memory-mapped interval timer with interrupt request FSM.
// Registers (relative to BASE_ADDR): TH 0x0, TL 0x4, TCON 0x8, SYSTICK 0xC.
// Build option: define SYSTICK_COUNT_EN to implement the free-running SYSTICK
// counter; otherwise 0xC reads 0 and ignores writes.
// Ports:
//   clk     : clock (rising edge)
//   reset   : synchronous active-high reset
//   bus     : CPU data bus (slave modport)
//   kernel  : CPU is in kernel mode
//   irq_ack : CPU took the interrupt vector this cycle
//   irq_ret : CPU returned from the handler
//   irq     : interrupt request, high only in PEND
// ----------------------------------------------------------------------------
module irq_timer_ctrl
    import irq_timer_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    irq_timer_ctrl_if.slave      bus,
    input  logic                 kernel,
    input  logic                 irq_ack,
    input  logic                 irq_ret,
    output logic                 irq
);

    logic              sel_th, sel_tl, sel_tcon;
    logic [31:0]       th, tl;
    logic [TCON_W-1:0] tcon;
    logic [31:0]       rdata_d;
    logic [1:0]        state_q, state_d;

    // Full-address compare: anything else in or outside the window is unmapped.
    assign sel_th   = (bus.addr == BASE_ADDR + OFF_TH);
    assign sel_tl   = (bus.addr == BASE_ADDR + OFF_TL);
    assign sel_tcon = (bus.addr == BASE_ADDR + OFF_TCON);

    timer_counter u_timer_counter (
        .clk       (clk),
        .reset     (reset),
        .wr_th_i   (bus.we && sel_th),
        .wr_tl_i   (bus.we && sel_tl),
        .wr_tcon_i (bus.we && sel_tcon),
        .wdata_i   (bus.wdata),
        .th_o      (th),
        .tl_o      (tl),
        .tcon_o    (tcon)
    );

`ifdef SYSTICK_COUNT_EN
    logic        sel_systick;
    logic [31:0] systick_q;

    assign sel_systick = (bus.addr == BASE_ADDR + OFF_SYSTICK);

    always_ff @(posedge clk) begin
        if (reset)                        systick_q <= '0;
        else if (bus.we && sel_systick)   systick_q <= bus.wdata;
        else                              systick_q <= systick_q + 32'd1;
    end
`endif

    always_comb begin
        rdata_d = 32'h0;
        if (bus.re) begin
            if (sel_th)        rdata_d = th;
            else if (sel_tl)   rdata_d = tl;
            else if (sel_tcon) rdata_d = {{(32-TCON_W){1'b0}}, tcon};
`ifdef SYSTICK_COUNT_EN
            else if (sel_systick) rdata_d = systick_q;
`endif
        end
    end

    assign bus.rdata = rdata_d;

    // Interrupt controller: user-mode pending status raises a request that
    // stays up until the CPU acks or software withdraws it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (tcon[TCON_STATUS] && tcon[TCON_IRQ_EN] && !kernel) state_d = ST_PEND;
            ST_PEND:
                if (irq_ack)                                          state_d = ST_SERVICE;
                else if (!tcon[TCON_STATUS] || !tcon[TCON_IRQ_EN])    state_d = ST_IDLE;
            ST_SERVICE:
                if (irq_ret) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign irq = (state_q == ST_PEND);

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_timer_ctrl
// Directed bench for irq_timer_ctrl: a table of single-cycle bus vectors for
// register decode/counting, then hand-written multi-cycle sequences for
// overflow, the interrupt FSM, write/overflow coincidence, reset and SYSTICK.
// ----------------------------------------------------------------------------
module tb_irq_timer_ctrl;
    import irq_timer_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic kernel = 1'b1;
    logic irq_ack = 1'b0;
    logic irq_ret = 1'b0;
    logic irq;

    irq_timer_ctrl_if bus_if ();

    irq_timer_ctrl #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .kernel  (kernel),
        .irq_ack (irq_ack),
        .irq_ret (irq_ret),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.we    = 1'b1;
        cyc();
        bus_if.we    = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_if.addr = a;
        bus_if.re   = 1'b1;
        #1;
        d = bus_if.rdata;
        bus_if.re   = 1'b0;
        check(name, d, exp);
    endtask

    function automatic vec_t mk(input logic we_, input logic re_, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.we = we_; v.re = re_; v.addr = a; v.wdata = d; v.exp_rdata = e; v.exp_irq = 1'b0;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.addr  = '0;
        bus_if.wdata = '0;
        bus_if.we    = 1'b0;
        bus_if.re    = 1'b0;

        // Register decode and counting; kernel=1 keeps the FSM idle.
        vecs[0]  = mk(0, 1, BASE + OFF_TH,   32'h0,         32'h0);
        vecs[1]  = mk(0, 1, BASE + OFF_TL,   32'h0,         32'h0);
        vecs[2]  = mk(0, 1, BASE + OFF_TCON, 32'h0,         32'h0);
        vecs[3]  = mk(0, 1, BASE + 32'h10,   32'h0,         32'h0);
        vecs[4]  = mk(1, 0, BASE + OFF_TH,   32'h1234_5678, 32'h0);
        vecs[5]  = mk(0, 1, BASE + OFF_TH,   32'h0,         32'h1234_5678);
        vecs[6]  = mk(1, 0, BASE + OFF_TL,   32'h10,        32'h0);
        vecs[7]  = mk(0, 1, BASE + OFF_TL,   32'h0,         32'h10);
        vecs[8]  = mk(0, 1, BASE + OFF_TL,   32'h0,         32'h10);
        vecs[9]  = mk(1, 0, BASE + OFF_TCON, 32'hFFFF_FFFC, 32'h0);
        vecs[10] = mk(0, 1, BASE + OFF_TCON, 32'h0,         32'h4);
        vecs[11] = mk(1, 0, BASE + OFF_TCON, 32'h0,         32'h0);
        vecs[12] = mk(1, 0, BASE + 32'h14,   32'h55,        32'h0);
        vecs[13] = mk(0, 1, BASE + 32'h14,   32'h0,         32'h0);
        vecs[14] = mk(0, 0, BASE + OFF_TH,   32'h0,         32'h0);
        vecs[15] = mk(1, 0, BASE - 32'h4,    32'hAAAA,      32'h0);
        vecs[16] = mk(0, 1, BASE + OFF_TH,   32'h0,         32'h1234_5678);
        vecs[17] = mk(1, 0, BASE + OFF_TCON, 32'h1,         32'h0);
        vecs[18] = mk(0, 1, BASE + OFF_TL,   32'h0,         32'h10);
        vecs[19] = mk(0, 1, BASE + OFF_TL,   32'h0,         32'h11);
        vecs[20] = mk(0, 1, BASE + OFF_TL,   32'h0,         32'h12);
        vecs[21] = mk(1, 0, BASE + OFF_TCON, 32'h0,         32'h0);
        vecs[22] = mk(0, 1, BASE + OFF_TL,   32'h0,         32'h14);
        vecs[23] = mk(0, 1, BASE + OFF_TL,   32'h0,         32'h14);
        vecs[24] = mk(0, 1, BASE + OFF_TCON, 32'h0,         32'h0);

        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;

        // Each vector: drive after the falling edge, compare, then the next
        // rising edge applies it.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            bus_if.we    = vecs[i].we;
            bus_if.re    = vecs[i].re;
            bus_if.addr  = vecs[i].addr;
            bus_if.wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d rdata", i), bus_if.rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
        end
        bus_if.we = 1'b0;
        bus_if.re = 1'b0;
        cyc();

        // Overflow reload, status set, irq one cycle later; ack then return.
        kernel = 1'b0;
        wr(BASE + OFF_TH, 32'hFFFF_FFFC);
        wr(BASE + OFF_TL, 32'hFFFF_FFFE);
        wr(BASE + OFF_TCON, 32'h3);
        cyc();
        cyc();
        chk_rd("wrap tl", BASE + OFF_TL, 32'hFFFF_FFFC);
        chk_rd("wrap tcon", BASE + OFF_TCON, 32'h7);
        check("wrap irq same cycle", {31'b0, irq}, 32'h0);
        cyc();
        check("wrap irq next cycle", {31'b0, irq}, 32'h1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        check("ack irq drop", {31'b0, irq}, 32'h0);
        wr(BASE + OFF_TCON, 32'h2);
        irq_ret = 1'b1;
        cyc();
        irq_ret = 1'b0;
        check("ret irq", {31'b0, irq}, 32'h0);
        cyc();
        check("idle irq", {31'b0, irq}, 32'h0);
        chk_rd("cleared tcon", BASE + OFF_TCON, 32'h2);

        // Status set in kernel mode: irq waits for user mode.
        kernel = 1'b1;
        wr(BASE + OFF_TCON, 32'h3);
        cyc();
        chk_rd("kernel tcon", BASE + OFF_TCON, 32'h7);
        check("kernel irq a", {31'b0, irq}, 32'h0);
        cyc();
        check("kernel irq b", {31'b0, irq}, 32'h0);
        cyc();
        check("kernel irq c", {31'b0, irq}, 32'h0);
        kernel = 1'b0;
        cyc();
        check("user irq", {31'b0, irq}, 32'h1);

        // Status still set after return: PEND again on the next cycle.
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        check("service irq", {31'b0, irq}, 32'h0);
        irq_ret = 1'b1;
        cyc();
        irq_ret = 1'b0;
        check("return idle irq", {31'b0, irq}, 32'h0);
        cyc();
        check("re-pend irq", {31'b0, irq}, 32'h1);

        // Software withdraws the request before the ack.
        wr(BASE + OFF_TCON, 32'h0);
        check("withdraw irq lag", {31'b0, irq}, 32'h1);
        cyc();
        check("withdraw irq", {31'b0, irq}, 32'h0);

        // TCON write on the overflow edge keeps the status bit.
        kernel = 1'b1;
        wr(BASE + OFF_TL, 32'hFFFF_FFFD);
        wr(BASE + OFF_TCON, 32'h3);
        cyc();
        cyc();
        wr(BASE + OFF_TCON, 32'h3);
        chk_rd("coincide tcon", BASE + OFF_TCON, 32'h7);
        chk_rd("coincide tl", BASE + OFF_TL, 32'hFFFF_FFFC);
        cyc();
        cyc();
        cyc();
        wr(BASE + OFF_TL, 32'h100);
        chk_rd("tl write beats reload", BASE + OFF_TL, 32'h100);

        // Reset from SERVICE, with a coincident store that must be lost.
        kernel = 1'b0;
        cyc();
        check("pre-reset irq", {31'b0, irq}, 32'h1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        check("pre-reset service irq", {31'b0, irq}, 32'h0);
        reset = 1'b1;
        wr(BASE + OFF_TH, 32'hAAAA);
        reset = 1'b0;
        check("reset irq", {31'b0, irq}, 32'h0);
        chk_rd("reset tcon", BASE + OFF_TCON, 32'h0);
        chk_rd("reset tl", BASE + OFF_TL, 32'h0);
        chk_rd("reset th", BASE + OFF_TH, 32'h0);
        chk_rd("unmapped 0x10", BASE + 32'h10, 32'h0);
        cyc();
        check("post-reset irq", {31'b0, irq}, 32'h0);
        chk_rd("post-reset tl", BASE + OFF_TL, 32'h0);

        // SYSTICK write and wrap.
        wr(BASE + OFF_SYSTICK, 32'hFFFF_FFFF);
`ifdef SYSTICK_COUNT_EN
        chk_rd("systick written", BASE + OFF_SYSTICK, 32'hFFFF_FFFF);
        cyc();
        chk_rd("systick wrap", BASE + OFF_SYSTICK, 32'h0);
        cyc();
        chk_rd("systick count", BASE + OFF_SYSTICK, 32'h1);
`else
        chk_rd("systick absent a", BASE + OFF_SYSTICK, 32'h0);
        cyc();
        chk_rd("systick absent b", BASE + OFF_SYSTICK, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_timer_ctrl.md
IRQ_TIMER_CTRL -- requirements
Module: irq_timer_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h40000000, meaning the peripheral window base (word-aligned).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-004 SHALL have port addr  input  32  meaning the CPU data-bus address.
REQ-005 SHALL have port wdata  input  32  meaning the CPU store data.
REQ-006 SHALL have port we  input  1  meaning a store strobe, sampled at the clock edge.
REQ-007 SHALL have port re  input  1  meaning a load strobe.
REQ-008 SHALL have port rdata  output  32  meaning load data, combinational from addr/re.
REQ-009 SHALL have port kernel  input  1  meaning the CPU is in kernel mode (PC[31]).
REQ-010 SHALL have port irq_ack  input  1  meaning the CPU selected the ILLOP vector this cycle.
REQ-011 SHALL have port irq_ret  input  1  meaning the CPU returned from the handler (jr to user address).
REQ-012 SHALL have port irq  output  1  meaning the interrupt request to the CPU control unit.

Function
REQ-013 SHALL decode registers TH at BASE+0x0, TL at BASE+0x4 and TCON at BASE+0x8 (bit0 enable, bit1 irq_en, bit2 status, bits 31:3 read 0).
REQ-014 SHALL increment TL by 1 each cycle while TCON[0]=1, and hold TL otherwise.
REQ-015 SHALL, when TL=32'hFFFFFFFF and TCON[0]=1, load TL<=TH and, if TCON[1]=1, set TCON[2] on the same edge.
REQ-016 SHALL give a bus write to TL priority over counting/reload in the same cycle.
REQ-017 SHALL, when a TCON write and an overflow status set coincide, write bits 1:0 from wdata and force bit2 to 1 (an interrupt is never lost).
REQ-018 SHALL drive rdata with the addressed register when re=1 and addr is mapped, else 32'h0.
REQ-019 SHALL ignore writes to unmapped addresses inside or outside the window.
REQ-020 SHALL run a 3-state FSM: IDLE, PEND, SERVICE.
REQ-021 SHALL transition IDLE->PEND when TCON[2]&TCON[1]&~kernel.
REQ-022 SHALL transition PEND->SERVICE on irq_ack, and PEND->IDLE if TCON[2] or TCON[1] clears before the ack.
REQ-023 SHALL transition SERVICE->IDLE on irq_ret; irq_ack in IDLE or SERVICE is ignored.
REQ-024 SHALL assert irq only in PEND (registered, 1-cycle latency from the status set to irq).
REQ-025 SHALL, when status is still set after SERVICE->IDLE and kernel=0, re-enter PEND on the next cycle.

Reset
REQ-026 SHALL, on reset, set TH=0, TL=0, TCON=0, FSM=IDLE and irq=0; reset overrides a coincident bus write.
REQ-027 SHALL, on reset during PEND or SERVICE, return to IDLE with irq deasserted on the next cycle.

Configuration
REQ-028 SHALL, with SYSTICK_COUNT_EN defined, provide SYSTICK at BASE+0xC, a 32-bit counter incremented every cycle, wrapping to 0, bus-writable with write priority, reset to 0.
REQ-029 SHALL, without SYSTICK_COUNT_EN, read BASE+0xC as 0 and ignore writes to it.

Structure
REQ-030 SHALL take register offsets, TCON bit indices and FSM state encodings from the shared CPU package.
REQ-031 SHALL implement TH/TL/reload/overflow in one sub-module, timer_counter, with the FSM and bus decode in the top level.

Verification
REQ-032 SHALL cover the following case: TH=FFFFFFFC, TL=FFFFFFFE, TCON=3 -> TL wraps to FFFFFFFC at cycle 2, status=1, irq=1 one cycle later.
REQ-033 SHALL cover the following case: irq=1, then irq_ack -> irq=0 next cycle; software clears TCON[2], then irq_ret -> IDLE, irq stays 0.
REQ-034 SHALL cover the following case: status set while kernel=1 -> irq stays 0 until kernel=0, then irq=1 one cycle later.
REQ-035 SHALL cover the following case: a TCON write of 32'h3 on the overflow cycle -> TCON reads 32'h7.
REQ-036 SHALL cover the following case: reset asserted in SERVICE -> irq=0, TCON=0, TL=0 next cycle; a read of BASE+0x10 returns 0.
REQ-037 SHALL cover the following case: with SYSTICK_COUNT_EN, write 32'hFFFFFFFF to BASE+0xC -> reads 0 two cycles later; without the macro, it reads 0 always.
